// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_prog
//  Purpose  : Programmable integer clock divider. A phase counter runs
//             0..N-1. clk_out is high for ceil(N/2) cycles and low for
//             floor(N/2) cycles of each period. A new divisor can be
//             requested at any time. It is applied only at a period wrap,
//             so a period is never cut short or stretched.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH       bit width of the divisor and the phase counter
//    DEFAULT_DIV divisor used after reset (legal range 2 .. 2^WIDTH-1)
//  Ports
//    clk       in   system clock, rising-edge active
//    reset     in   asynchronous active-low reset
//    enable    in   phase counter advances when high, holds when low
//    div_load  in   single-cycle request to load div_in as the new divisor
//    div_in    in   requested divisor (0 and 1 are treated as 2)
//    clk_out   out  registered divided clock
//    tick      out  one-cycle pulse on the edge after each period wrap
//    busy      out  a loaded divisor is waiting for the next wrap
//    load_ack  out  one-cycle pulse on the edge a new divisor takes effect
//    div_cur   out  divisor currently in use
// ============================================================================
module clk_div_prog #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 102
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_in,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic             load_ack,
  output logic [WIDTH-1:0] div_cur
);

  localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO       = WIDTH'(2);
  localparam logic [WIDTH:0]   ONE_EXT   = (WIDTH + 1)'(1);

  // Phase counter and the divisor waiting for the next wrap.
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] pending;

  // Combinational next-state terms.
  logic             wrap;
  logic [WIDTH-1:0] div_in_clamped;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] div_next;
  logic [WIDTH:0]   hi_next;
  logic             clk_out_next;
  logic             apply_new;

  // Divisors below 2 cannot produce a two-phase output, so they are raised
  // to 2 before being stored or applied.
  always_comb begin
    div_in_clamped = div_in;
    if (div_in < TWO) begin
      div_in_clamped = TWO;
    end
  end

  // div_cur is always >= 2, so div_cur - 1 cannot underflow. The counter
  // never exceeds div_cur - 1, so it stays within WIDTH bits.
  assign wrap = enable && (cnt == (div_cur - ONE));

  // At a wrap, a direct load has priority over the pending value.
  // Otherwise the pending value is used if one is waiting.
  always_comb begin
    div_next  = div_cur;
    apply_new = 1'b0;
    if (wrap) begin
      if (div_load) begin
        div_next  = div_in_clamped;
        apply_new = 1'b1;
      end else if (busy) begin
        div_next  = pending;
        apply_new = 1'b1;
      end
    end
  end

  assign cnt_next = wrap ? '0 : (cnt + ONE);

  // High-phase length. It is evaluated with the divisor that governs the
  // cycle being entered, so a wrap edge already uses the new divisor.
  // One extra bit keeps N+1 from overflowing when N = 2^WIDTH-1.
  assign hi_next      = ({1'b0, div_next} + ONE_EXT) >> 1;
  assign clk_out_next = ({1'b0, cnt_next} < hi_next);

  // Phase counter, divided clock and tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      tick <= wrap;
      if (enable) begin
        cnt     <= cnt_next;
        clk_out <= clk_out_next;
      end
    end
  end

  // Divisor hand-off. A load outside a wrap cycle parks the value in
  // pending. A later load before the wrap simply overwrites it. Any wrap
  // retires the pending state, whether or not a divisor was applied.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cur  <= RESET_DIV;
      pending  <= '0;
      busy     <= 1'b0;
      load_ack <= 1'b0;
    end else begin
      load_ack <= apply_new;
      div_cur  <= div_next;
      if (wrap) begin
        busy <= 1'b0;
      end else if (div_load) begin
        pending <= div_in_clamped;
        busy    <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the bit width of divisor and phase counter.
REQ-002 The block SHALL have parameter DEFAULT_DIV, default 102, giving the divisor loaded at reset. 50 MHz/102 matches the existing fixed 500 kHz-class divider. DEFAULT_DIV SHALL be in the range 2..2^WIDTH-1.
REQ-003 clk  input  1  system clock; all state SHALL change on its rising edge only.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  when high, the phase counter advances; when low, the phase counter holds.
REQ-006 div_load  input  1  single-cycle request to load a new divisor.
REQ-007 div_in  input  WIDTH  new divisor value, sampled when div_load is high.
REQ-008 clk_out  output  1  registered divided clock.
REQ-009 tick  output  1  registered one-cycle pulse at each period wrap.
REQ-010 busy  output  1  high while a loaded divisor waits to be applied.
REQ-011 load_ack  output  1  registered one-cycle pulse on the edge a new divisor takes effect.
REQ-012 div_cur  output  WIDTH  divisor currently in use (N).

Function
REQ-013 The phase counter cnt SHALL run 0..N-1 and wrap to 0; "wrap cycle" means enable=1 and cnt==N-1.
REQ-014 On each enabled edge, cnt SHALL take the value cnt_next: 0 in a wrap cycle, otherwise cnt+1.
REQ-015 On each enabled edge, clk_out SHALL take the value (cnt_next < HI), where HI=(N+1)>>1. The high phase is therefore ceil(N/2) cycles and the low phase is floor(N/2) cycles.
REQ-016 tick SHALL be 1 for exactly the edge following a wrap cycle, and 0 otherwise.
REQ-017 When enable=0, cnt and clk_out SHALL hold, and tick SHALL be 0.
REQ-018 A div_load on an edge that is not a wrap cycle SHALL store div_in in a pending register and set busy=1 on that edge.
REQ-019 A div_load while busy=1 SHALL overwrite the pending value; only the last value loaded is applied.
REQ-020 On a wrap edge with busy=1 and no div_load, N SHALL take the pending value, busy SHALL clear, and load_ack SHALL pulse.
REQ-021 On a wrap edge with div_load=1, div_in SHALL be applied directly, bypassing any pending value. busy SHALL clear and load_ack SHALL pulse.
REQ-022 A new N SHALL first govern the cycle starting at cnt=0 after the wrap. HI for the clk_out evaluation on that wrap edge SHALL use the new N.
REQ-023 div_in values 0 or 1 SHALL be clamped to 2 when stored or applied. div_cur SHALL never be less than 2.
REQ-024 While enable=0, loads SHALL still be accepted into the pending register but SHALL NOT be applied until a wrap cycle occurs.
REQ-025 The counter SHALL NOT overflow WIDTH bits; N-1 SHALL be computed in WIDTH bits.

Reset
REQ-026 While reset=0, cnt SHALL be 0, clk_out 0, tick 0, busy 0, load_ack 0, and div_cur DEFAULT_DIV; the pending register SHALL be cleared.
REQ-027 Reset assertion SHALL take effect immediately, without a clock edge, including mid-period and with a load pending.
REQ-028 Deassertion SHALL be followed by normal operation from the first enabled edge.
REQ-029 clk_out SHALL stay 0 until the first enabled edge after reset.

Verification
REQ-030 Bench SHALL use DEFAULT_DIV=4 and enable=1 from reset release. Required response: clk_out over edges 1..8 = 1,0,0,1,1,0,0,1; tick=1 after edges 4 and 8 only.
REQ-031 Bench SHALL use an odd divisor N=5 in steady state. Required response: clk_out high 3 cycles, low 2 cycles; tick period 5.
REQ-032 Bench SHALL apply div_load with div_in=6 at cnt=1 while N=4. Required response: busy=1 until the wrap; the current period completes at 4 cycles; load_ack pulses once; div_cur=6; the next period is 3 high / 3 low.
REQ-033 Bench SHALL issue div_load=8, then div_load=10 before the wrap, then a div_load with div_in=1 on a wrap cycle. Required response: 10 is applied at the first wrap; 2 is applied at the later wrap with no busy assertion; clk_out then toggles every cycle.
REQ-034 Bench SHALL hold enable=0 for 7 cycles mid-period. Required response: cnt and clk_out are frozen and tick=0; resuming continues from the same phase.
REQ-035 Bench SHALL assert reset asynchronously between clock edges with busy=1. Required response: outputs go to reset values immediately, div_cur=DEFAULT_DIV, and the pending value is discarded.
